hdcpu_ctrl_gen2: RTL and testbench
==================================

# hdcpu_ctrl_gen2

Second-generation hardwired controller for the HD-CPU teaching machine. It generates the W1/W2/W3 beat timing internally; it is no longer driven by an external timing board. It decodes console modes and the instruction opcode into the datapath control word. Relative to the first generation it adds a parametrised register-select width with a register-index counter for console register access, START/STOP run control with single-step, and a maskable interrupt entry beat with EI/DI instructions.

## Interface
- REG_SEL_W, 2: width of one register-select field; SEL is 2*REG_SEL_W bits, {dest, src}.
- STEP_EN, 1: 1 enables the STEP input; 0 ties single-step off.
- T3 in 1: clock. All state updates on the rising edge.
- CLR in 1: reset, asynchronous, active-high.
- START in 1: run request, sampled in IDLE only.
- SW in 3: console mode. Latched at START into sw_q; decode uses sw_q only.
- IR in 4: opcode IR[7:4].
- C, Z in 1 each: ALU flags.
- INTR in 1: level-sensitive interrupt request.
- STEP in 1: single-instruction mode.
- W out 3: one-hot beat {W3,W2,W1}; 000 in IDLE and in the INT beat.
- ST0 out 1: second-phase flag for the memory console modes.
- HALTED, INTA, IE out 1 each: idle indicator, interrupt acknowledge, interrupt enable.
- Control word out, combinational from state: LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD, ARINC, SELCTL, MEMW, LIR, SBUS, MBUS (1 bit each); S (4 bits); SEL (2*REG_SEL_W bits).

## Operation
- States: IDLE, BEAT (W1/W2/W3), INT.
- Every control output is 0 in IDLE and INT, except INTA, which is 1 in INT.
- **START in IDLE:**
  - Latch sw_q.
  - If SW differs from the previous sw_q, clear ST0 and the register index k.
  - Go to W1.
- **Beat length per operation:**
  - Memory console modes (001, 010): W1 only.
  - Register console modes (011, 100): W1 only.
  - Run-mode instructions: W1, W2.
  - LD and ST: W1, W2, W3.
- **Stop rule.** After the last beat, return to IDLE when any of the following holds; otherwise go to W1:
  - any console mode;
  - the STP instruction (1110);
  - STEP_EN && STEP.
- **Mode 001, memory write:**
  - ST0=0: SBUS, LAR; ST0 set.
  - ST0=1: SBUS, MEMW, ARINC.
  - SELCTL=1 in both cases.
- **Mode 010, memory read:**
  - ST0=0: SBUS, LAR; ST0 set.
  - ST0=1: MBUS, ARINC.
  - SELCTL=1 in both cases.
- **Mode 011, register read:**
  - Outputs: SELCTL=1, SEL={k, k+1}.
  - Then k += 2, modulo 2^REG_SEL_W.
- **Mode 100, register write:**
  - Outputs: SELCTL=1, SBUS=1, DRW=1, SEL={k, k}.
  - Then k += 1, modulo 2^REG_SEL_W.
- **Mode 000, run. W1 (fetch):** LIR, PCINC.
- **Mode 000, run. W2 by opcode:**
  - ADD 0001: S=1001, CIN, ABUS, DRW, LDZ, LDC.
  - SUB 0010: S=0110, ABUS, DRW, LDZ, LDC.
  - AND 0011: M, S=1011, ABUS, DRW, LDZ.
  - INC 0100: S=0000, ABUS, DRW, LDZ, LDC.
  - LD 0101: M, S=1010, ABUS, LAR.
  - ST 0110: M, S=1111, ABUS, LAR.
  - JC 0111: PCADD=C.
  - JZ 1000: PCADD=Z.
  - JMP 1001: M, S=1111, ABUS, LPC.
  - OUT 1010: M, S=1010, ABUS.
  - XOR 1011: M, S=0110, ABUS, DRW, LDZ.
  - OR 1100: M, S=1110, ABUS, DRW, LDZ.
  - EI 1101, DI 1111, STP 1110: no datapath strobes.
  - Undefined opcodes act as NOP.
- **Mode 000, run. W3:**
  - LD: DRW, MBUS.
  - ST: M, S=1010, ABUS, MEMW.
- **IE updates:** set at the end of EI's W2; cleared at the end of DI's W2; cleared at the end of INT.
- **Interrupt check** at the last beat of a run-mode instruction:
  - If IE (the registered value before that edge's update) && INTR && the stop rule is false: go to INT, then W1.
  - Consequence: EI's own end never enters INT.
  - The stop rule has priority. A pending request is re-evaluated at the next instruction end.
- sw_q values 101, 110 and 111 execute as one NOP W1 beat, then IDLE.

## Timing
- **CLR asserted:** immediately, and at any point mid-instruction, the block resets to:
  - state IDLE, W=000, HALTED=1;
  - ST0=0, IE=0, k=0, sw_q=000;
  - all control outputs 0.
- **Beat timing:**
  - The first W1 begins at the edge that samples START=1.
  - Each beat lasts one T3 cycle.
- **Cycles per operation:**
  - 2-beat instruction: 2 cycles, or 3 with an INT beat.
  - LD and ST: 3 cycles.
  - Console operation: 1 cycle.
- **Flag timing:**
  - HALTED=1 exactly in IDLE.
  - ST0 and k update on the edge that ends the console beat.
- START while not in IDLE is ignored.

## Test plan
- **Reset:**
  - Stimulus: CLR=1 mid-W2 of ADD.
  - Required: W=000, HALTED=1, IE=0, all controls 0 in the same cycle; first W1 only on START after CLR drops.
- **Memory write sequence:**
  - Stimulus: SW=001, START, then START, then START.
  - Required: cycle 1 LAR=1, ST0→1; next two ops MEMW=1, ARINC=1, LAR=0; each op is followed by IDLE.
- **Register write, REG_SEL_W=2:**
  - Stimulus: SW=100, five STARTs.
  - Required: SEL sequence 0000, 0101, 1010, 1111, 0000 (k wraps); DRW=1 on each.
- **Run program:**
  - Stimulus: SW=000; program LD, ADD, STP.
  - Required: W sequence 001, 010, 100, 001, 010, 001, 010, then IDLE; LD W3 has DRW=1, MBUS=1; ADD W2 has S=1001, CIN=1.
- **Interrupt:**
  - Stimulus: INTR=1 held; program EI, INC.
  - Required: no INT after EI; after INC's W2, one cycle with W=000, INTA=1; then IE=0 and W1 resumes.
- **Step:**
  - Stimulus: STEP_EN=1, STEP=1, INTR=1, IE=1.
  - Required: halt after each instruction with no INT beat; with STEP=0, INT follows the next instruction's W2.

Source files
------------

// File: rtl/hdcpu_ctrl_gen2.sv
// hdcpu_ctrl_gen2: hardwired HD-CPU controller with internal W1/W2/W3 beats, console modes, run control and interrupts
module hdcpu_ctrl_gen2 #(
  parameter int REG_SEL_W = 2,
  parameter bit STEP_EN   = 1'b1
) (
  input  logic                   T3,
  input  logic                   CLR,
  input  logic                   START,
  input  logic [2:0]             SW,
  input  logic [3:0]             IR,
  input  logic                   C,
  input  logic                   Z,
  input  logic                   INTR,
  input  logic                   STEP,
  output logic [2:0]             W,
  output logic                   ST0,
  output logic                   HALTED,
  output logic                   INTA,
  output logic                   IE,
  output logic                   LDC,
  output logic                   LDZ,
  output logic                   CIN,
  output logic                   M,
  output logic                   ABUS,
  output logic                   DRW,
  output logic                   PCINC,
  output logic                   LPC,
  output logic                   LAR,
  output logic                   PCADD,
  output logic                   ARINC,
  output logic                   SELCTL,
  output logic                   MEMW,
  output logic                   LIR,
  output logic                   SBUS,
  output logic                   MBUS,
  output logic [3:0]             S,
  output logic [2*REG_SEL_W-1:0] SEL
);
  typedef enum logic [1:0] {ST_IDLE, ST_BEAT, ST_INT} state_t;
  state_t state_q, state_d;
  logic [2:0] w_q, w_d, sw_q, sw_d;
  logic st0_q, st0_d, ie_q, ie_d;
  logic [REG_SEL_W-1:0] k_q, k_d;
  logic run, ldst, last, stop;
  assign run  = sw_q == 3'b000;
  assign ldst = run && (IR == 4'b0101 || IR == 4'b0110);
  assign last = run ? (ldst ? w_q[2] : w_q[1]) : w_q[0];
  assign stop = !run || IR == 4'b1110 || (STEP_EN && STEP);
  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      w_q     <= 3'b000;
      sw_q    <= 3'b000;
      st0_q   <= 1'b0;
      ie_q    <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      sw_q    <= sw_d;
      st0_q   <= st0_d;
      ie_q    <= ie_d;
      k_q     <= k_d;
    end
  end
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    sw_d    = sw_q;
    st0_d   = st0_q;
    ie_d    = ie_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: if (START) begin
        state_d = ST_BEAT;
        w_d     = 3'b001;
        sw_d    = SW;
        if (SW != sw_q) begin
          st0_d = 1'b0;
          k_d   = '0;
        end
      end
      ST_BEAT: begin
        w_d = w_q << 1;
        if (run && w_q[1] && IR == 4'b1101) ie_d = 1'b1;
        if (run && w_q[1] && IR == 4'b1111) ie_d = 1'b0;
        if (sw_q == 3'b001 || sw_q == 3'b010) st0_d = 1'b1;
        if (sw_q == 3'b011) k_d = k_q + REG_SEL_W'(2);
        if (sw_q == 3'b100) k_d = k_q + REG_SEL_W'(1);
        if (last) begin
          w_d     = 3'b001;
          // stop rule outranks a pending interrupt; IE here is the pre-edge value
          state_d = stop ? ST_IDLE : (ie_q && INTR) ? ST_INT : ST_BEAT;
        end
      end
      ST_INT: begin
        state_d = ST_BEAT;
        w_d     = 3'b001;
        ie_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    {LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD, ARINC, SELCTL, MEMW, LIR, SBUS, MBUS} = '0;
    S      = 4'b0000;
    SEL    = '0;
    W      = state_q == ST_BEAT ? w_q : 3'b000;
    HALTED = state_q == ST_IDLE;
    INTA   = state_q == ST_INT;
    ST0    = st0_q;
    IE     = ie_q;
    if (state_q == ST_BEAT) begin
      case (sw_q)
        3'b001: begin
          SELCTL = 1'b1;
          SBUS   = 1'b1;
          LAR    = !st0_q;
          MEMW   = st0_q;
          ARINC  = st0_q;
        end
        3'b010: begin
          SELCTL = 1'b1;
          SBUS   = !st0_q;
          LAR    = !st0_q;
          MBUS   = st0_q;
          ARINC  = st0_q;
        end
        3'b011: begin
          SELCTL = 1'b1;
          SEL    = {k_q, k_q + REG_SEL_W'(1)};
        end
        3'b100: begin
          SELCTL = 1'b1;
          SBUS   = 1'b1;
          DRW    = 1'b1;
          SEL    = {k_q, k_q};
        end
        3'b000: begin
          if (w_q[0]) {LIR, PCINC} = 2'b11;
          if (w_q[1]) begin
            case (IR)
              4'b0001: begin S = 4'b1001; {CIN, ABUS, DRW, LDZ, LDC} = '1; end
              4'b0010: begin S = 4'b0110; {ABUS, DRW, LDZ, LDC} = '1; end
              4'b0011: begin S = 4'b1011; {M, ABUS, DRW, LDZ} = '1; end
              4'b0100: begin S = 4'b0000; {ABUS, DRW, LDZ, LDC} = '1; end
              4'b0101: begin S = 4'b1010; {M, ABUS, LAR} = '1; end
              4'b0110: begin S = 4'b1111; {M, ABUS, LAR} = '1; end
              4'b0111: PCADD = C;
              4'b1000: PCADD = Z;
              4'b1001: begin S = 4'b1111; {M, ABUS, LPC} = '1; end
              4'b1010: begin S = 4'b1010; {M, ABUS} = '1; end
              4'b1011: begin S = 4'b0110; {M, ABUS, DRW, LDZ} = '1; end
              4'b1100: begin S = 4'b1110; {M, ABUS, DRW, LDZ} = '1; end
              default: S = 4'b0000;
            endcase
          end
          if (w_q[2] && IR == 4'b0101) {DRW, MBUS} = 2'b11;
          if (w_q[2] && IR == 4'b0110) begin S = 4'b1010; {M, ABUS, MEMW} = '1; end
        end
        default: S = 4'b0000;
      endcase
    end
  end
endmodule

// File: tb/tb_hdcpu_ctrl_gen2.sv
// tb_hdcpu_ctrl_gen2: directed-vector bench for the HD-CPU gen2 controller
module tb_hdcpu_ctrl_gen2;
  logic T3 = 1'b0, CLR = 1'b1, START = 1'b0, C = 1'b0, Z = 1'b0, INTR = 1'b0, STEP = 1'b0;
  logic [2:0] SW = 3'b000;
  logic [3:0] IR = 4'b0000;
  logic [2:0] W;
  logic ST0, HALTED, INTA, IE;
  logic LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD, ARINC, SELCTL, MEMW, LIR, SBUS, MBUS;
  logic [3:0] S, SEL;
  logic [15:0] ctl;
  int passed = 0, total = 0;
  localparam logic [15:0] B_LDC = 16'h8000, B_LDZ = 16'h4000, B_CIN = 16'h2000, B_M = 16'h1000,
    B_ABUS = 16'h0800, B_DRW = 16'h0400, B_PCINC = 16'h0200, B_LPC = 16'h0100, B_LAR = 16'h0080,
    B_PCADD = 16'h0040, B_ARINC = 16'h0020, B_SELCTL = 16'h0010, B_MEMW = 16'h0008, B_LIR = 16'h0004,
    B_SBUS = 16'h0002, B_MBUS = 16'h0001;
  localparam logic [15:0] FETCH = B_LIR | B_PCINC;
  assign ctl = {LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD, ARINC, SELCTL, MEMW, LIR, SBUS, MBUS};
  always #5 T3 = ~T3;
  hdcpu_ctrl_gen2 #(.REG_SEL_W(2), .STEP_EN(1'b1)) dut (
    .T3(T3), .CLR(CLR), .START(START), .SW(SW), .IR(IR), .C(C), .Z(Z), .INTR(INTR), .STEP(STEP),
    .W(W), .ST0(ST0), .HALTED(HALTED), .INTA(INTA), .IE(IE),
    .LDC(LDC), .LDZ(LDZ), .CIN(CIN), .M(M), .ABUS(ABUS), .DRW(DRW), .PCINC(PCINC), .LPC(LPC),
    .LAR(LAR), .PCADD(PCADD), .ARINC(ARINC), .SELCTL(SELCTL), .MEMW(MEMW), .LIR(LIR), .SBUS(SBUS),
    .MBUS(MBUS), .S(S), .SEL(SEL)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic go(input logic [3:0] ir);
    @(negedge T3);
    IR = ir;
    START = 1'b1;
    @(posedge T3);
    #1 START = 1'b0;
  endtask
  task automatic bt(input string tag, input logic [2:0] w, input logic [15:0] c, input logic [3:0] s);
    @(negedge T3);
    #1;
    chk({tag, ".W"}, 16'(W), 16'(w));
    chk({tag, ".ctl"}, ctl, c);
    chk({tag, ".S"}, 16'(S), 16'(s));
  endtask
  task automatic idle(input string tag);
    @(negedge T3);
    #1;
    chk({tag, ".HALTED"}, 16'(HALTED), 16'd1);
    chk({tag, ".W"}, 16'(W), 16'd0);
  endtask
  task automatic con(input string tag, input logic [15:0] c, input logic [3:0] sel, input logic st0);
    go(4'b0000);
    @(negedge T3);
    #1;
    chk({tag, ".W"}, 16'(W), 16'd1);
    chk({tag, ".ctl"}, ctl, c);
    chk({tag, ".SEL"}, 16'(SEL), 16'(sel));
    idle(tag);
    chk({tag, ".ST0"}, 16'(ST0), 16'(st0));
  endtask
  initial begin
    repeat (2) @(negedge T3);
    #1;
    chk("rst.HALTED", 16'(HALTED), 16'd1);
    chk("rst.ctl", ctl, 16'd0);
    CLR = 1'b0;
    // CLR mid-W2 of ADD
    go(4'b0001);
    bt("add0.w1", 3'b001, FETCH, 4'b0000);
    bt("add0.w2", 3'b010, B_LDC | B_LDZ | B_CIN | B_ABUS | B_DRW, 4'b1001);
    CLR = 1'b1;
    #1;
    chk("clr.W", 16'(W), 16'd0);
    chk("clr.HALTED", 16'(HALTED), 16'd1);
    chk("clr.IE", 16'(IE), 16'd0);
    chk("clr.ctl", ctl, 16'd0);
    chk("clr.S", 16'(S), 16'd0);
    @(negedge T3);
    CLR = 1'b0;
    idle("clr.idle1");
    idle("clr.idle2");
    go(4'b1110);
    bt("stp.w1", 3'b001, FETCH, 4'b0000);
    bt("stp.w2", 3'b010, 16'd0, 4'b0000);
    idle("stp.end");
    // memory write, then read
    SW = 3'b001;
    con("mw1", B_SELCTL | B_SBUS | B_LAR, 4'b0000, 1'b1);
    con("mw2", B_SELCTL | B_SBUS | B_MEMW | B_ARINC, 4'b0000, 1'b1);
    con("mw3", B_SELCTL | B_SBUS | B_MEMW | B_ARINC, 4'b0000, 1'b1);
    SW = 3'b010;
    con("mr1", B_SELCTL | B_SBUS | B_LAR, 4'b0000, 1'b1);
    con("mr2", B_SELCTL | B_MBUS | B_ARINC, 4'b0000, 1'b1);
    // register write, k wraps
    SW = 3'b100;
    con("rw0", B_SELCTL | B_SBUS | B_DRW, 4'b0000, 1'b0);
    con("rw1", B_SELCTL | B_SBUS | B_DRW, 4'b0101, 1'b0);
    con("rw2", B_SELCTL | B_SBUS | B_DRW, 4'b1010, 1'b0);
    con("rw3", B_SELCTL | B_SBUS | B_DRW, 4'b1111, 1'b0);
    con("rw4", B_SELCTL | B_SBUS | B_DRW, 4'b0000, 1'b0);
    // register read, k steps by 2
    SW = 3'b011;
    con("rr0", B_SELCTL, 4'b0001, 1'b0);
    con("rr1", B_SELCTL, 4'b1011, 1'b0);
    con("rr2", B_SELCTL, 4'b0001, 1'b0);
    SW = 3'b101;
    con("nop101", 16'd0, 4'b0000, 1'b0);
    // run program LD, ADD, STP
    SW = 3'b000;
    go(4'b0101);
    bt("ld.w1", 3'b001, FETCH, 4'b0000);
    bt("ld.w2", 3'b010, B_M | B_ABUS | B_LAR, 4'b1010);
    bt("ld.w3", 3'b100, B_DRW | B_MBUS, 4'b0000);
    bt("add.w1", 3'b001, FETCH, 4'b0000);
    IR = 4'b0001;
    bt("add.w2", 3'b010, B_LDC | B_LDZ | B_CIN | B_ABUS | B_DRW, 4'b1001);
    bt("stp2.w1", 3'b001, FETCH, 4'b0000);
    IR = 4'b1110;
    bt("stp2.w2", 3'b010, 16'd0, 4'b0000);
    idle("prog.end");
    // interrupt: EI then INC with INTR held
    INTR = 1'b1;
    go(4'b1101);
    bt("ei.w1", 3'b001, FETCH, 4'b0000);
    bt("ei.w2", 3'b010, 16'd0, 4'b0000);
    chk("ei.IEpre", 16'(IE), 16'd0);
    bt("inc.w1", 3'b001, FETCH, 4'b0000);
    chk("inc.IE", 16'(IE), 16'd1);
    IR = 4'b0100;
    bt("inc.w2", 3'b010, B_ABUS | B_DRW | B_LDZ | B_LDC, 4'b0000);
    bt("int", 3'b000, 16'd0, 4'b0000);
    chk("int.INTA", 16'(INTA), 16'd1);
    chk("int.HALTED", 16'(HALTED), 16'd0);
    bt("post.w1", 3'b001, FETCH, 4'b0000);
    chk("post.IE", 16'(IE), 16'd0);
    chk("post.INTA", 16'(INTA), 16'd0);
    IR = 4'b1110;
    bt("post.w2", 3'b010, 16'd0, 4'b0000);
    idle("int.end");
    // step mode halts after each instruction even with IE && INTR
    STEP = 1'b1;
    go(4'b1101);
    bt("sei.w1", 3'b001, FETCH, 4'b0000);
    bt("sei.w2", 3'b010, 16'd0, 4'b0000);
    idle("sei.end");
    chk("sei.IE", 16'(IE), 16'd1);
    C = 1'b1;
    go(4'b0111);
    bt("sjc.w1", 3'b001, FETCH, 4'b0000);
    bt("sjc.w2", 3'b010, B_PCADD, 4'b0000);
    idle("sjc.end");
    chk("sjc.INTA", 16'(INTA), 16'd0);
    STEP = 1'b0;
    go(4'b0001);
    bt("sadd.w1", 3'b001, FETCH, 4'b0000);
    bt("sadd.w2", 3'b010, B_LDC | B_LDZ | B_CIN | B_ABUS | B_DRW, 4'b1001);
    bt("sint", 3'b000, 16'd0, 4'b0000);
    chk("sint.INTA", 16'(INTA), 16'd1);
    bt("sres.w1", 3'b001, FETCH, 4'b0000);
    IR = 4'b1110;
    bt("sres.w2", 3'b010, 16'd0, 4'b0000);
    idle("step.end");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
